tc_pl_cap_gp_ctl_mc: RTL
========================

Name: tc_pl_cap_gp_ctl_mc

Overview:
- Multi-channel capture-control bridge between PS GPIO and the PL capture engines.
- Per channel, the block:
  - turns a PS GPIO trigger level into a single-cycle capture trigger;
  - tracks busy/complete with a timeout watchdog;
  - flags triggers rejected while busy;
  - holds sticky status bits until the PS clears them.
- Sits between the PS GPIO block and the CH_NUM capture engines.
- Generalises the single-channel capture-complete handshake.

Parameters:
- CH_NUM, 4, number of independent capture channels (1..16).
- TO_W, 24, width of the per-channel timeout counter.
- TO_CYC, 12500000, timeout in clk125 cycles (100 ms); 0 disables the timeout.

Ports:
- clk125  in  1  system clock, 125 MHz.
- rst  in  1  synchronous, active-high reset.
- cap_cing  in  CH_NUM  per-channel capture-in-progress level from the engine.
- cap_cmpt  in  CH_NUM  per-channel capture-complete pulse from the engine.
- cap_trig  out  CH_NUM  per-channel capture trigger, 1-cycle pulse, registered.
- gp_trig  in  CH_NUM  PS GPIO trigger level; a rising edge requests a capture.
- gp_clr  in  CH_NUM  PS status-clear strobe, per channel.
- gp_stat  out  4*CH_NUM  status word {to_flag, ovr_flag, cmpt_flag, cap_cing}, each field CH_NUM bits wide, channel i at bit i of its field.

Behaviour:
- Reset: cap_trig=0, cmpt_flag=0, ovr_flag=0, to_flag=0, all FSMs IDLE, counters=0.
- Reset: the edge-detect register for gp_trig resets to all-ones, so a level held high through reset produces no trigger.
- Edge detect: rise[i] = gp_trig[i] & ~gp_trig_d[i], where gp_trig_d is gp_trig registered once.
- Per-channel FSM, 2 states: IDLE, BUSY.
  - IDLE & rise: cap_trig[i]=1 on the next cycle for exactly 1 cycle; cmpt_flag[i] and to_flag[i] cleared; counter cleared; go to BUSY.
  - BUSY & cap_cmpt: cmpt_flag[i]=1; go to IDLE.
  - BUSY & TO_CYC!=0 & counter==TO_CYC-1: to_flag[i]=1; go to IDLE.
  - BUSY, otherwise: counter increments by 1, saturating, no wrap.
  - BUSY & rise: no trigger issued; ovr_flag[i]=1; stay in BUSY.
- Latency: gp_trig rising at clk edge n (first sampled high) -> cap_trig high during cycle n+1.
- cap_cmpt while IDLE: sets cmpt_flag[i] (late/unsolicited completion is still reported); state unchanged.
- cap_cmpt and timeout in the same cycle: completion wins; to_flag stays 0.
- gp_clr[i]: clears cmpt_flag[i], ovr_flag[i] and to_flag[i] on the next edge.
  - Any same-cycle set event takes priority over gp_clr.
  - gp_clr never changes FSM state.
- gp_stat cap_cing field: cap_cing passed through combinationally; the flag fields come directly from flops.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-capture: FSM returns to IDLE and cap_trig drops in the same cycle. Any subsequent cap_cmpt is treated as an IDLE completion.

Optional Feature:
- Macro: CAP_GP_SYNC_EN.
- Defined:
  - gp_trig and gp_clr each pass through a 2-flop synchroniser before use (PS GPIO in an asynchronous domain).
  - Trigger latency becomes 3 cycles.
  - gp_clr takes effect 3 cycles after assertion, and must be held at least 2 cycles.
  - Synchroniser flops for gp_trig reset to all-ones; those for gp_clr reset to 0.
- Undefined: gp_trig and gp_clr are synchronous to clk125 and used directly as described above.

Test Plan:
- Reset with gp_trig[0]=1 held, release rst -> no cap_trig pulse; gp_trig 0->1 -> cap_trig[0] high exactly 1 cycle, 1 cycle after the edge.
- Ch0: trigger, cap_cmpt[0] pulse 50 cycles later -> gp_stat cmpt bit0=1; gp_clr[0] 1 cycle -> bit0=0 on the next cycle.
- TO_CYC=100: trigger ch1, no cap_cmpt -> to_flag bit1=1 exactly 100 cycles after entering BUSY; FSM back in IDLE; next rise re-triggers and clears to_flag.
- Ch2 BUSY, second rising edge on gp_trig[2] -> no cap_trig[2]; ovr_flag bit2=1; same-cycle gp_clr[2] with a new rise -> ovr_flag stays 1.
- All 4 channels triggered in one cycle -> cap_trig=4'b1111 for 1 cycle; cap_cmpt on ch3 only -> gp_stat cmpt field = 4'b1000.
- cap_cmpt and timeout in the same cycle (TO_CYC=10, cmpt on cycle 10) -> cmpt_flag=1, to_flag=0.

Source files
------------

// File: rtl/tc_pl_cap_gp_ctl_mc.sv
// PS GPIO to PL capture-engine bridge: per-channel 1-cycle trigger, busy/timeout tracking, overrun and sticky status flags.
// Trigger latency 1 cycle; define CAP_GP_SYNC_EN to add 2-flop synchronisers on gp_trig/gp_clr (latency 3 cycles).
module tc_pl_cap_gp_ctl_mc #(
    parameter int CH_NUM = 4,
    parameter int TO_W   = 24,
    parameter int TO_CYC = 12500000
) (
    input  logic                clk125,
    input  logic                rst,
    input  logic [CH_NUM-1:0]   cap_cing,
    input  logic [CH_NUM-1:0]   cap_cmpt,
    output logic [CH_NUM-1:0]   cap_trig,
    input  logic [CH_NUM-1:0]   gp_trig,
    input  logic [CH_NUM-1:0]   gp_clr,
    output logic [4*CH_NUM-1:0] gp_stat
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    localparam bit              TO_EN   = (TO_CYC != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    logic [CH_NUM-1:0] w_trig_in;
    logic [CH_NUM-1:0] w_clr_in;
    logic [CH_NUM-1:0] w_rise;

    state_t            r_state [CH_NUM];
    logic [TO_W-1:0]   r_cnt   [CH_NUM];
    logic [CH_NUM-1:0] r_trig_d;
    logic [CH_NUM-1:0] r_cap_trig;
    logic [CH_NUM-1:0] r_cmpt_flag;
    logic [CH_NUM-1:0] r_ovr_flag;
    logic [CH_NUM-1:0] r_to_flag;

`ifdef CAP_GP_SYNC_EN
    logic [CH_NUM-1:0] r_trig_s1;
    logic [CH_NUM-1:0] r_trig_s2;
    logic [CH_NUM-1:0] r_clr_s1;
    logic [CH_NUM-1:0] r_clr_s2;

    // Trigger stages reset high so a level held through reset never looks like a rising edge.
    always_ff @(posedge clk125) begin
        if (rst) begin
            r_trig_s1 <= '1;
            r_trig_s2 <= '1;
            r_clr_s1  <= '0;
            r_clr_s2  <= '0;
        end else begin
            r_trig_s1 <= gp_trig;
            r_trig_s2 <= r_trig_s1;
            r_clr_s1  <= gp_clr;
            r_clr_s2  <= r_clr_s1;
        end
    end

    assign w_trig_in = r_trig_s2;
    assign w_clr_in  = r_clr_s2;
`else
    assign w_trig_in = gp_trig;
    assign w_clr_in  = gp_clr;
`endif

    assign w_rise = w_trig_in & ~r_trig_d;

    // Later assignments override earlier ones, so set events beat gp_clr and completion beats timeout.
    always_ff @(posedge clk125) begin
        if (rst) begin
            r_trig_d    <= '1;
            r_cap_trig  <= '0;
            r_cmpt_flag <= '0;
            r_ovr_flag  <= '0;
            r_to_flag   <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_trig_d <= w_trig_in;
            for (int i = 0; i < CH_NUM; i++) begin
                r_cap_trig[i] <= 1'b0;
                if (w_clr_in[i]) begin
                    r_cmpt_flag[i] <= 1'b0;
                    r_ovr_flag[i]  <= 1'b0;
                    r_to_flag[i]   <= 1'b0;
                end
                case (r_state[i])
                    ST_IDLE: begin
                        if (w_rise[i]) begin
                            r_cap_trig[i]  <= 1'b1;
                            r_cmpt_flag[i] <= 1'b0;
                            r_to_flag[i]   <= 1'b0;
                            r_cnt[i]       <= '0;
                            r_state[i]     <= ST_BUSY;
                        end
                        // Late or unsolicited completions are still reported.
                        if (cap_cmpt[i]) begin
                            r_cmpt_flag[i] <= 1'b1;
                        end
                    end
                    ST_BUSY: begin
                        if (w_rise[i]) begin
                            r_ovr_flag[i] <= 1'b1;
                        end
                        if (cap_cmpt[i]) begin
                            r_cmpt_flag[i] <= 1'b1;
                            r_state[i]     <= ST_IDLE;
                        end else if (TO_EN && (r_cnt[i] == TO_LAST)) begin
                            r_to_flag[i] <= 1'b1;
                            r_state[i]   <= ST_IDLE;
                        end else if (r_cnt[i] != '1) begin
                            r_cnt[i] <= r_cnt[i] + TO_W'(1);
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign cap_trig = r_cap_trig;
    assign gp_stat  = {r_to_flag, r_ovr_flag, r_cmpt_flag, cap_cing};

endmodule
